mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Multi-cycle controller for the EX-stage MULT/MULTU unit of the five-stage MIPS core.
//  - Sequences one shared WIDTH-bit ripple adder as a radix-2 shift-add multiplier.
//  - Accepts operands on a start pulse and produces the 2*WIDTH-bit product in HI/LO.
//  - Drives busy so hazard logic stalls mfhi/mflo; supports pipeline flush (abort).
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH (HI = upper, LO = lower)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  start      in   1      request; sampled only in IDLE or DONE
//  signed_op  in   1      1 = MULT (two's complement), 0 = MULTU
//  op_a       in   WIDTH  multiplicand (rs)
//  op_b       in   WIDTH  multiplier (rt)
//  flush      in   1      abort in-flight operation
//  busy       out  1      high in RUN and FIX
//  done       out  1      one-cycle pulse when hi/lo become valid
//  hi         out  WIDTH  product bits [2W-1:W]
//  lo         out  WIDTH  product bits [W-1:0]
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge)
//  - state=IDLE; busy=0, done=0, hi=0, lo=0; counter and internal registers = 0.
//  - Reset has priority over everything, including mid-operation: the result is discarded.
//  States: IDLE, RUN, FIX, DONE
//  IDLE/DONE + start (and !flush)
//  - Latch mcand=|op_a|, acc={0,|op_b|}; abs only if signed_op.
//  - Latch neg = signed_op & (op_a[W-1]^op_b[W-1]); cnt=0; next state RUN.
//  - |0x80..0| = 0x80..0 is valid as an unsigned magnitude.
//  RUN, each cycle
//  - sum{c,s} = acc[2W-1:W] + (acc[0] ? mcand : 0), via the shared adder.
//  - acc <= {c, s, acc[W-1:1]}; cnt++.
//  - After the WIDTH-th cycle (cnt==WIDTH-1), go to FIX.
//  FIX (1 cycle)
//  - If neg, acc <= ~acc + 1 over 2W bits; else hold. Next state DONE.
//  DONE (1 cycle)
//  - done=1; hi/lo <= acc and update at this edge, visible in the DONE cycle.
//  - Next state: RUN if start is accepted, else IDLE.
//  Latency
//  - start sampled at edge 0; done high in cycle WIDTH+2 (34 for WIDTH=32); busy high WIDTH+1 cycles.
//  hi/lo
//  - Hold their last value until the next DONE; they never show partial products.
//  start while busy
//  - Ignored; no queueing. The issuing stage must stall on busy.
//  flush
//  - Highest priority after reset, in any state: next state IDLE, busy=0 next cycle, no done, hi/lo unchanged.
//  - flush and start in the same cycle: flush wins, start is dropped.
//  Zero operand
//  - Still takes the full WIDTH cycles; no early exit, so latency is fixed.
//  Arithmetic
//  - Adder is WIDTH+1 result bits (carry kept).
//  - Negation is a 2W-bit two's complement; overflow is impossible for either signedness.
// STRUCTURE
//  - Package mult_seq_pkg: typedef enum logic [1:0] {IDLE,RUN,FIX,DONE} mult_state_t; localparam MULT_W_DEF=32.
//  - Sub-module ripple_adder #(WIDTH): chain of full_adder cells, (a,b,cin) -> (s,cout).
//  - This block holds the FSM, counter ($clog2(WIDTH) bits), acc (2W bits), mcand, neg and hi/lo registers.
// TESTING (WIDTH=32)
//  - MULTU 7 x 6 -> done exactly 34 cycles after start; hi=0x00000000, lo=0x0000002A; busy high 33 cycles.
//  - MULT -3 x 5 (0xFFFFFFFD, 0x5) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  - MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0; MULT 0x80000000 x 1 -> hi=0xFFFFFFFF, lo=0x80000000.
//  - Prior result 42; start 2x3, flush at cycle 10 -> busy=0 at cycle 11, no done, hi/lo stay 0/42.
//  - Start during busy ignored; start held in DONE -> back-to-back op, next done 34 cycles later.
//  - rst_n=0 at cycle 5 of an op -> next cycle busy=0, done=0, hi=lo=0, state IDLE.

Source files
------------

// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and defaults for the sequential MULT/MULTU controller.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    localparam int MULT_W_DEF = 32;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Request/result bundle between the EX stage and the multiplier controller.
// start is accepted only while busy is low; a request seen while busy is
// dropped, not queued. done pulses for one cycle when hi/lo hold a new product.
interface mult_seq_ctrl_if #(parameter int WIDTH = 32);

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_op, op_a, op_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, signed_op, op_a, op_b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_seq_ctrl_adder.sv
// Ripple-carry adder built from full_adder cells; shared by every RUN cycle.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = cin;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end
endmodule

// File: rtl/mult_seq_ctrl.sv
// Radix-2 shift-add multiplier controller: magnitudes are multiplied over
// WIDTH cycles, then the sign is applied in a single fix-up cycle.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_seq_ctrl_if.slave        bus,
    output mult_state_t           state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mult_state_t        state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic               neg;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               load, shift, fix;
    logic [WIDTH-1:0]   mag_a, mag_b, addend, sum;
    logic               carry;
    logic [2*WIDTH-1:0] acc_fixed;

    // |0x80..0| wraps back to 0x80..0, which is the correct unsigned magnitude.
    assign mag_a = (bus.signed_op && bus.op_a[WIDTH-1]) ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
    assign mag_b = (bus.signed_op && bus.op_b[WIDTH-1]) ? (~bus.op_b + WIDTH'(1)) : bus.op_b;

    assign addend    = acc[0] ? mcand : '0;
    assign acc_fixed = neg ? (~acc + (2*WIDTH)'(1)) : acc;

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        fix        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt == LAST) state_next = FIX;
            end
            FIX: begin
                fix        = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        // Flush abandons the operation from any state and drops a same-cycle start.
        if (bus.flush) begin
            state_next = IDLE;
            load       = 1'b0;
            shift      = 1'b0;
            fix        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                mcand <= mag_a;
                acc   <= {{WIDTH{1'b0}}, mag_b};
                neg   <= bus.signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                cnt   <= '0;
            end
            if (shift) begin
                acc <= {carry, sum, acc[WIDTH-1:1]};
                cnt <= cnt + CW'(1);
            end
            // Result registers load with the signed product so they show it in DONE.
            if (fix) begin
                acc  <= acc_fixed;
                hi_q <= acc_fixed[2*WIDTH-1:WIDTH];
                lo_q <= acc_fixed[WIDTH-1:0];
            end
        end
    end

    assign bus.busy  = (state == RUN) || (state == FIX);
    assign bus.done  = (state == DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with hand-computed products and cycle counts.
module tb_mult_seq_ctrl;
    import mult_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    mult_state_t state_dbg;
    int          n_vec;
    int          n_err;

    mult_seq_ctrl_if #(.WIDTH(32)) bus ();

    mult_seq_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in cycle 1 of the operation.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts cycles (starting at 1) until done; -1 if it never arrives.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 1;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
        if (bus.done !== 1'b1) cyc = -1;
    endtask

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || state_dbg !== IDLE) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h state=%0d, required 0 0 0 0 IDLE",
                     bus.busy, bus.done, bus.hi, bus.lo, state_dbg);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_multu_latency();
        int cyc, bcnt;
        issue(1'b0, 32'd7, 32'd6);
        wait_done(cyc, bcnt);
        n_vec++;
        if (cyc !== 34) begin
            n_err++;
            $display("FAIL multu_latency: done in cycle %0d, required 34", cyc);
        end
        n_vec++;
        if (bcnt !== 33) begin
            n_err++;
            $display("FAIL multu_busy: busy cycles %0d, required 33", bcnt);
        end
        n_vec++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h2A) begin
            n_err++;
            $display("FAIL multu_7x6: hi=%h lo=%h, required 00000000 0000002a", bus.hi, bus.lo);
        end
        tick();
        n_vec++;
        if (bus.done !== 1'b0 || state_dbg !== IDLE || bus.lo !== 32'h2A) begin
            n_err++;
            $display("FAIL done_pulse: done=%b state=%0d lo=%h, required 0 IDLE 0000002a",
                     bus.done, state_dbg, bus.lo);
        end
    endtask

    typedef struct packed {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic test_products();
        vec_t vecs[8];
        int   cyc, bcnt;
        vecs = '{
            '{1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
            '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
            '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
            '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000},
            '{1'b1, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6},
            '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001},
            '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000},
            '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780}
        };
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_done(cyc, bcnt);
            n_vec++;
            if (cyc !== 34 || bus.hi !== vecs[i].hi || bus.lo !== vecs[i].lo) begin
                n_err++;
                $display("FAIL product[%0d] %h*%h s=%b: cyc=%0d hi=%h lo=%h, required 34 %h %h",
                         i, vecs[i].a, vecs[i].b, vecs[i].sgn, cyc, bus.hi, bus.lo, vecs[i].hi, vecs[i].lo);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        int cyc, bcnt, pulses;
        issue(1'b0, 32'd7, 32'd6);
        wait_done(cyc, bcnt);
        tick();
        issue(1'b0, 32'd2, 32'd3);
        repeat (9) tick();
        bus.flush = 1'b1;
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre: busy=%b in cycle 10, required 1", bus.busy);
        end
        tick();
        bus.flush = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0 || state_dbg !== IDLE) begin
            n_err++;
            $display("FAIL flush_busy: busy=%b state=%0d in cycle 11, required 0 IDLE", bus.busy, state_dbg);
        end
        count_done(40, pulses);
        n_vec++;
        if (pulses !== 0 || bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
            n_err++;
            $display("FAIL flush_result: done pulses=%0d hi=%h lo=%h, required 0 00000000 0000002a",
                     pulses, bus.hi, bus.lo);
        end
        bus.flush = 1'b1;
        issue(1'b0, 32'd5, 32'd5);
        bus.flush = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0 || state_dbg !== IDLE) begin
            n_err++;
            $display("FAIL flush_start: busy=%b state=%0d, required 0 IDLE", bus.busy, state_dbg);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, bcnt, pulses;
        issue(1'b0, 32'd7, 32'd6);
        repeat (4) tick();
        issue(1'b0, 32'd100, 32'd100);
        wait_done(cyc, bcnt);
        n_vec++;
        if (cyc !== 29 || bus.lo !== 32'd42 || bus.hi !== 32'h0) begin
            n_err++;
            $display("FAIL busy_start: cyc=%0d hi=%h lo=%h, required 29 00000000 0000002a", cyc, bus.hi, bus.lo);
        end
        tick();
        count_done(40, pulses);
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL busy_start_queued: extra done pulses=%0d, required 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        issue(1'b0, 32'd7, 32'd6);
        wait_done(cyc, bcnt);
        issue(1'b0, 32'd3, 32'd4);
        n_vec++;
        if (bus.busy !== 1'b1 || state_dbg !== RUN) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b state=%0d, required 1 RUN", bus.busy, state_dbg);
        end
        wait_done(cyc, bcnt);
        n_vec++;
        if (cyc !== 34 || bus.lo !== 32'd12 || bus.hi !== 32'h0) begin
            n_err++;
            $display("FAIL b2b_result: cyc=%0d hi=%h lo=%h, required 34 00000000 0000000c", cyc, bus.hi, bus.lo);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int cyc, bcnt;
        issue(1'b1, 32'hFFFFFFFD, 32'd5);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || state_dbg !== IDLE) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h state=%0d, required 0 0 0 0 IDLE",
                     bus.busy, bus.done, bus.hi, bus.lo, state_dbg);
        end
        issue(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC);
        wait_done(cyc, bcnt);
        n_vec++;
        if (cyc !== 34 || bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
            n_err++;
            $display("FAIL reset_recover: cyc=%0d hi=%h lo=%h, required 34 00000000 0000000c", cyc, bus.hi, bus.lo);
        end
        tick();
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.flush     = 1'b0;
        test_reset();
        test_multu_latency();
        test_products();
        test_flush();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
